// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and the byte-merge helper for the register file
package regfile_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NREAD = 2;
   localparam int NBYTES = DEF_DATA_W / 8;
   localparam int MAX_W = 256;
   localparam int MAX_NB = MAX_W / 8;
   function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_d,
                                                   input logic [MAX_W-1:0] new_d,
                                                   input logic [MAX_NB-1:0] be);
      byte_merge = old_d;
      for (int b = 0; b < MAX_NB; b++)
         if (be[b]) byte_merge[8*b +: 8] = new_d[8*b +: 8];
   endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bus into the register file and scoreboard
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD = 2
);
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic [DATA_W/8-1:0]      wr_be;
   logic [NREAD*ADDR_W-1:0]  rd_addr;
   logic [NREAD*DATA_W-1:0]  rd_data;
   logic [NREAD-1:0]         rd_busy;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     iss_ok;
   logic                     flush;
   logic [2**ADDR_W-1:0]     busy_vec;
   logic [ADDR_W:0]          n_busy;
   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_addr, iss_en, iss_addr, flush,
      input  rd_data, rd_busy, iss_ok, busy_vec, n_busy
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_addr, iss_en, iss_addr, flush,
      output rd_data, rd_busy, iss_ok, busy_vec, n_busy
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, issue acceptance and read-port hazard flags
module rf_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int NREAD = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic                    flush,
   input  logic [NREAD*ADDR_W-1:0] rd_addr,
   output logic                    iss_ok,
   output logic [NREAD-1:0]        rd_busy,
   output logic [2**ADDR_W-1:0]    busy_vec,
   output logic [ADDR_W:0]         n_busy
);
   localparam int DEPTH = 2**ADDR_W;
   localparam bit ZR = ZERO_REG != 0;
   logic [DEPTH-1:0] nxt;
   logic [ADDR_W:0]  cnt;
   logic             iss_set;
   assign iss_ok = iss_en && !flush && (!busy_vec[iss_addr] || (wr_en && wr_addr == iss_addr));
   assign iss_set = iss_ok && !(ZR && iss_addr == '0);
   // next busy bits: writeback clears, an accepted issue overrides the clear, flush wipes everything
   always_comb begin
      nxt = busy_vec;
      if (wr_en) nxt[wr_addr] = 1'b0;
      if (iss_set) nxt[iss_addr] = 1'b1;
      if (flush) nxt = '0;
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt += (ADDR_W+1)'(nxt[i]);
   end
   // registered scoreboard with its population count kept in step
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         busy_vec <= '0;
         n_busy <= '0;
      end else begin
         busy_vec <= nxt;
         n_busy <= cnt;
      end
   for (genvar k = 0; k < NREAD; k++) begin : g_busy
      logic [ADDR_W-1:0] a;
      assign a = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_busy[k] = busy_vec[a] && !(wr_en && wr_addr == a);
   end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: byte-enable register file with write bypass, zero register and busy scoreboard
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NREAD = DEF_NREAD,
   parameter int ZERO_REG = 1
) (
   input logic clock,
   input logic reset_n,
   regfile_scoreboard_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam bit ZR = ZERO_REG != 0;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] merged;
   logic              wr_take;
   assign merged = DATA_W'(byte_merge(MAX_W'(mem[bus.wr_addr]), MAX_W'(bus.wr_data), MAX_NB'(bus.wr_be)));
   assign wr_take = bus.wr_en && !(ZR && bus.wr_addr == '0);
   // storage array: byte-merged writeback, zero register never written
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_take) begin
         mem[bus.wr_addr] <= merged;
      end
   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = bus.rd_addr[k*ADDR_W +: ADDR_W];
      assign bus.rd_data[k*DATA_W +: DATA_W] = (ZR && a == '0) ? '0 :
                                               (bus.wr_en && bus.wr_addr == a) ? merged : mem[a];
   end
   rf_scoreboard #(
      .ADDR_W(ADDR_W),
      .NREAD(NREAD),
      .ZERO_REG(ZERO_REG)
   ) u_sb (
      .clock(clock),
      .reset_n(reset_n),
      .iss_en(bus.iss_en),
      .iss_addr(bus.iss_addr),
      .wr_en(bus.wr_en),
      .wr_addr(bus.wr_addr),
      .flush(bus.flush),
      .rd_addr(bus.rd_addr),
      .iss_ok(bus.iss_ok),
      .rd_busy(bus.rd_busy),
      .busy_vec(bus.busy_vec),
      .n_busy(bus.n_busy)
   );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenario tests for the register file and scoreboard
module tb_regfile_scoreboard;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus ();
   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus.slave)
   );
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
      bus.iss_en = 0; bus.iss_addr = '0; bus.flush = 0;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      bus.rd_addr = {a1, a0};
      #1;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
      cyc();
      bus.wr_en = 0;
   endtask

   task automatic do_iss(input logic [4:0] a);
      bus.iss_en = 1; bus.iss_addr = a;
      cyc();
      bus.iss_en = 0;
   endtask

   task automatic test_reset();
      n_tests++;
      if (bus.busy_vec !== 32'h0 || bus.n_busy !== 6'd0) begin
         n_fail++; $display("FAIL reset_init: busy_vec=%h n_busy=%0d, want 0/0", bus.busy_vec, bus.n_busy);
      end
      do_write(5, 32'h11223344, 4'hF);
      do_iss(10);
      set_rd(5, 10);
      n_tests++;
      if (bus.rd_data[31:0] !== 32'h11223344) begin
         n_fail++; $display("FAIL reset_pre_rd: got %h want 11223344", bus.rd_data[31:0]);
      end
      n_tests++;
      if (bus.n_busy !== 6'd1 || bus.busy_vec[10] !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre_busy: n_busy=%0d bit10=%b want 1/1", bus.n_busy, bus.busy_vec[10]);
      end
      #2 reset_n = 0;
      #1;
      n_tests++;
      if (bus.rd_data !== 64'h0 || bus.busy_vec !== 32'h0 || bus.n_busy !== 6'd0) begin
         n_fail++; $display("FAIL reset_async: rd=%h busy_vec=%h n_busy=%0d want all 0", bus.rd_data, bus.busy_vec, bus.n_busy);
      end
      bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 32'hDEADBEEF; bus.wr_be = 4'hF;
      bus.iss_en = 1; bus.iss_addr = 11;
      @(posedge clock); #1;
      idle();
      #1;
      n_tests++;
      if (bus.rd_data[31:0] !== 32'h0 || bus.busy_vec !== 32'h0 || bus.n_busy !== 6'd0) begin
         n_fail++; $display("FAIL reset_hold: rd=%h busy_vec=%h n_busy=%0d want all 0", bus.rd_data[31:0], bus.busy_vec, bus.n_busy);
      end
      reset_n = 1;
      #1;
   endtask

   task automatic test_byte_write();
      do_write(5, 32'h11223344, 4'hF);
      set_rd(5, 0);
      bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 32'hAABBCCDD; bus.wr_be = 4'b0101;
      #1;
      n_tests++;
      if (bus.rd_data[31:0] !== 32'h11BB33DD) begin
         n_fail++; $display("FAIL byte_bypass: got %h want 11bb33dd", bus.rd_data[31:0]);
      end
      cyc();
      bus.wr_en = 0;
      #1;
      n_tests++;
      if (bus.rd_data[31:0] !== 32'h11BB33DD) begin
         n_fail++; $display("FAIL byte_stored: got %h want 11bb33dd", bus.rd_data[31:0]);
      end
      do_write(5, 32'hFFFFFFFF, 4'b0000);
      #1;
      n_tests++;
      if (bus.rd_data[31:0] !== 32'h11BB33DD) begin
         n_fail++; $display("FAIL byte_be0: got %h want 11bb33dd", bus.rd_data[31:0]);
      end
   endtask

   task automatic test_zero_reg();
      set_rd(5, 0);
      bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 32'hFFFFFFFF; bus.wr_be = 4'hF;
      bus.iss_en = 1; bus.iss_addr = 0;
      #1;
      n_tests++;
      if (bus.rd_data[63:32] !== 32'h0 || bus.iss_ok !== 1'b1) begin
         n_fail++; $display("FAIL zero_same: rd=%h iss_ok=%b want 0/1", bus.rd_data[63:32], bus.iss_ok);
      end
      cyc();
      idle();
      #1;
      n_tests++;
      if (bus.rd_data[63:32] !== 32'h0 || bus.busy_vec[0] !== 1'b0 || bus.n_busy !== 6'd0 || bus.rd_busy[1] !== 1'b0) begin
         n_fail++; $display("FAIL zero_after: rd=%h bit0=%b n_busy=%0d rd_busy=%b want 0/0/0/0",
                            bus.rd_data[63:32], bus.busy_vec[0], bus.n_busy, bus.rd_busy[1]);
      end
   endtask

   task automatic test_hazard();
      set_rd(7, 0);
      bus.iss_en = 1; bus.iss_addr = 7;
      #1;
      n_tests++;
      if (bus.iss_ok !== 1'b1) begin
         n_fail++; $display("FAIL haz_issue: iss_ok=%b want 1", bus.iss_ok);
      end
      cyc();
      bus.iss_en = 0;
      #1;
      n_tests++;
      if (bus.busy_vec[7] !== 1'b1 || bus.n_busy !== 6'd1 || bus.rd_busy[0] !== 1'b1) begin
         n_fail++; $display("FAIL haz_busy: bit7=%b n_busy=%0d rd_busy=%b want 1/1/1", bus.busy_vec[7], bus.n_busy, bus.rd_busy[0]);
      end
      bus.iss_en = 1; bus.iss_addr = 7;
      #1;
      n_tests++;
      if (bus.iss_ok !== 1'b0) begin
         n_fail++; $display("FAIL haz_reissue: iss_ok=%b want 0", bus.iss_ok);
      end
      cyc();
      bus.iss_en = 0;
      n_tests++;
      if (bus.n_busy !== 6'd1 || bus.busy_vec !== 32'h80) begin
         n_fail++; $display("FAIL haz_reject_hold: busy_vec=%h n_busy=%0d want 00000080/1", bus.busy_vec, bus.n_busy);
      end
      bus.wr_en = 1; bus.wr_addr = 7; bus.wr_data = 32'h54; bus.wr_be = 4'hF;
      #1;
      n_tests++;
      if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[31:0] !== 32'h54) begin
         n_fail++; $display("FAIL haz_wb_bypass: rd_busy=%b rd=%h want 0/54", bus.rd_busy[0], bus.rd_data[31:0]);
      end
      cyc();
      bus.wr_en = 0;
      n_tests++;
      if (bus.busy_vec[7] !== 1'b0 || bus.n_busy !== 6'd0) begin
         n_fail++; $display("FAIL haz_cleared: bit7=%b n_busy=%0d want 0/0", bus.busy_vec[7], bus.n_busy);
      end
   endtask

   task automatic test_simultaneous();
      do_iss(9);
      bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'h99; bus.wr_be = 4'hF;
      bus.iss_en = 1; bus.iss_addr = 9;
      #1;
      n_tests++;
      if (bus.iss_ok !== 1'b1) begin
         n_fail++; $display("FAIL sim_iss_ok: iss_ok=%b want 1", bus.iss_ok);
      end
      cyc();
      idle();
      n_tests++;
      if (bus.busy_vec !== 32'h200 || bus.n_busy !== 6'd1) begin
         n_fail++; $display("FAIL sim_busy: busy_vec=%h n_busy=%0d want 00000200/1", bus.busy_vec, bus.n_busy);
      end
   endtask

   task automatic test_flush();
      do_iss(3);
      do_iss(4);
      do_iss(6);
      n_tests++;
      if (bus.busy_vec !== 32'h258 || bus.n_busy !== 6'd4) begin
         n_fail++; $display("FAIL flush_pre: busy_vec=%h n_busy=%0d want 00000258/4", bus.busy_vec, bus.n_busy);
      end
      bus.iss_en = 1; bus.iss_addr = 8; bus.flush = 1;
      bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 32'h77; bus.wr_be = 4'hF;
      #1;
      n_tests++;
      if (bus.iss_ok !== 1'b0) begin
         n_fail++; $display("FAIL flush_iss_ok: iss_ok=%b want 0", bus.iss_ok);
      end
      cyc();
      idle();
      set_rd(3, 8);
      n_tests++;
      if (bus.busy_vec !== 32'h0 || bus.n_busy !== 6'd0) begin
         n_fail++; $display("FAIL flush_clear: busy_vec=%h n_busy=%0d want 0/0", bus.busy_vec, bus.n_busy);
      end
      n_tests++;
      if (bus.rd_data[31:0] !== 32'h77) begin
         n_fail++; $display("FAIL flush_write: got %h want 77", bus.rd_data[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      do_write(1, 32'h01020304, 4'hF);
      do_write(2, 32'hA0B0C0D0, 4'hF);
      do_write(1, 32'hFF000000, 4'b1000);
      set_rd(1, 2);
      n_tests++;
      if (bus.rd_data !== {32'hA0B0C0D0, 32'hFF020304}) begin
         n_fail++; $display("FAIL b2b_data: got %h want a0b0c0d0ff020304", bus.rd_data);
      end
      do_iss(1);
      do_iss(2);
      n_tests++;
      if (bus.n_busy !== 6'd2 || bus.rd_busy !== 2'b11) begin
         n_fail++; $display("FAIL b2b_busy: n_busy=%0d rd_busy=%b want 2/11", bus.n_busy, bus.rd_busy);
      end
      do_write(1, 32'h0, 4'b0000);
      n_tests++;
      if (bus.busy_vec !== 32'h4 || bus.n_busy !== 6'd1 || bus.rd_data[31:0] !== 32'hFF020304) begin
         n_fail++; $display("FAIL b2b_be0_clear: busy_vec=%h n_busy=%0d rd=%h want 00000004/1/ff020304",
                            bus.busy_vec, bus.n_busy, bus.rd_data[31:0]);
      end
   endtask

   initial begin
      idle();
      bus.rd_addr = '0;
      #12 reset_n = 1;
      test_reset();
      test_byte_write();
      test_zero_reg();
      test_hazard();
      test_simultaneous();
      test_flush();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
